// File: rtl/spm_bank_arb.sv
// Round-robin arbiter for one scratchpad bank port, with locked bursts and read-response tracking.
// Optional feature macro: SPM_ARB_WR_PRIO_EN (writes win the IDLE search over reads).
module spm_bank_arb #(
  parameter int N_REQ           = 3,
  parameter int NUM_LANE        = 128,
  parameter int DATA_WIDTH      = 64,
  parameter int URAM_ADDR_WIDTH = 12,
  parameter int RD_LAT          = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     i_req_valid,
  output logic [N_REQ-1:0]                     o_req_ready,
  input  logic [N_REQ-1:0]                     i_req_wr,
  input  logic [N_REQ-1:0]                     i_req_last,
  input  logic [N_REQ*URAM_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [N_REQ*NUM_LANE*DATA_WIDTH-1:0] i_req_wdata,
  input  logic [N_REQ*NUM_LANE-1:0]            i_req_mask,
  output logic [URAM_ADDR_WIDTH-1:0]           o_bank_addr,
  output logic [NUM_LANE*DATA_WIDTH-1:0]       o_bank_wr_data,
  output logic                                 o_bank_en,
  output logic                                 o_bank_wr_en,
  output logic [NUM_LANE-1:0]                  o_bank_col_mask,
  output logic [N_REQ-1:0]                     o_rsp_valid,
  output logic                                 o_busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = URAM_ADDR_WIDTH;
  localparam int LW = NUM_LANE * DATA_WIDTH;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] cand;
  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic [PW-1:0]   gidx;
  logic            accept;
  int              idx;

  logic [PW-1:0]   bank_idx_q;
  logic [RD_LAT-1:0] trk_vld;
  logic [PW-1:0]   trk_idx [RD_LAT];

  // Rotating search: iterate from farthest to nearest so the first hit at/after ptr wins.
  always_comb begin
    cand     = i_req_valid;
    pick     = ptr_q;
    pick_vld = 1'b0;
    idx      = 0;
`ifdef SPM_ARB_WR_PRIO_EN
    if (|(i_req_valid & i_req_wr)) cand = i_req_valid & i_req_wr;
`endif
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (cand[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    o_req_ready = '0;
    gidx        = (state_q == BURST) ? owner_q : pick;
    if (!rst) begin
      if (state_q == BURST)  o_req_ready = ONE << owner_q;
      else if (pick_vld)     o_req_ready = ONE << pick;
    end
    accept = |(o_req_ready & i_req_valid);
    if (accept) begin
      if (i_req_last[gidx]) begin
        state_d = IDLE;
        ptr_d   = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
      end else begin
        state_d = BURST;
        owner_d = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      ptr_q           <= '0;
      o_bank_en       <= 1'b0;
      o_bank_wr_en    <= 1'b0;
      o_bank_addr     <= '0;
      o_bank_wr_data  <= '0;
      o_bank_col_mask <= '0;
      bank_idx_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      o_bank_en    <= accept;
      o_bank_wr_en <= accept & i_req_wr[gidx];
      if (accept) begin
        o_bank_addr     <= i_req_addr[int'(gidx)*AW +: AW];
        o_bank_wr_data  <= i_req_wdata[int'(gidx)*LW +: LW];
        o_bank_col_mask <= i_req_mask[int'(gidx)*NUM_LANE +: NUM_LANE];
        bank_idx_q      <= gidx;
      end
    end
  end

  // Stage 0 captures the read visible on the bank port; the last stage lines up with read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) trk_idx[i] <= '0;
    end else begin
      trk_vld[0] <= o_bank_en & ~o_bank_wr_en;
      trk_idx[0] <= bank_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_idx[i] <= trk_idx[i-1];
      end
    end
  end

  assign o_rsp_valid = trk_vld[RD_LAT-1] ? (ONE << trk_idx[RD_LAT-1]) : '0;
  assign o_busy      = (state_q == BURST) | (|trk_vld);

endmodule
